e_mdu: RTL and testbench

//  Execute-stage multiply/divide unit with HI/LO registers. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E,

---
 rtl/mdu_pkg.sv | 17 +
 rtl/mdu_calc.sv | 32 +++
 rtl/e_mdu.sv | 73 +++++++
 tb/tb_e_mdu.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM encoding and default latencies shared by the multiply/divide unit.
package mdu_pkg;
    typedef enum logic [3:0] {
        MDU_NONE = 4'd0,
        MULT     = 4'd1,
        MULTU    = 4'd2,
        DIV      = 4'd3,
        DIVU     = 4'd4,
        MFHI     = 4'd5,
        MFLO     = 4'd6,
        MTHI     = 4'd7,
        MTLO     = 4'd8
    } mdu_op_e;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_e;
    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational product/quotient/remainder; divide-by-zero passes current HI/LO through.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] HI,
    input  logic [31:0] LO,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n
);
    logic [63:0] sp, up;
    logic [31:0] bs, sq, sr, uq, ur;
    logic        dz, ovf;
    always_comb begin
        sp = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        up = {32'd0, A} * {32'd0, B};
        dz = B == 32'd0;
        ovf = A == 32'h8000_0000 && B == 32'hFFFF_FFFF;
        // A safe divisor of 1 gives the required 0x80000000 / 0 result for the overflow case
        bs = (dz || ovf) ? 32'd1 : B;
        sq = $signed(A) / $signed(bs);
        sr = $signed(A) % $signed(bs);
        uq = A / bs;
        ur = A % bs;
        {hi_n, lo_n} = op == MULT  ? sp :
                       op == MULTU ? up :
                       op == DIV   ? (dz ? {HI, LO} : {sr, sq}) :
                       op == DIVU  ? (dz ? {HI, LO} : {ur, uq}) : {HI, LO};
    end
endmodule

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with HI/LO, fixed-latency busy counter and MFHI/MFLO read port.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUAns
);
    mdu_state_e  state, state_n;
    logic [3:0]  cnt;
    logic [31:0] hi_q, lo_q, hi_c, lo_c;
    logic        accept, is_mul, is_div;
    assign accept = state == IDLE && start && !Req;
    assign is_mul = op == MULT || op == MULTU;
    assign is_div = op == DIV || op == DIVU;
    mdu_calc u_calc (
        .op   (op),
        .A    (A),
        .B    (B),
        .HI   (HI),
        .LO   (LO),
        .hi_n (hi_c),
        .lo_n (lo_c)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end
    always_comb begin
        state_n = state == IDLE ? ((accept && (is_mul || is_div)) ? BUSY : IDLE)
                                : (cnt == 4'd1 ? IDLE : BUSY);
    end
    always_comb begin
        busy   = state == BUSY;
        MDUAns = op == MFHI ? HI : op == MFLO ? LO : 32'd0;
    end
    // Operands are captured at acceptance so later A/B changes cannot disturb the op in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= 4'd0;
            hi_q <= 32'd0;
            lo_q <= 32'd0;
            HI   <= 32'd0;
            LO   <= 32'd0;
        end else if (state == IDLE) begin
            if (accept && (is_mul || is_div)) begin
                hi_q <= hi_c;
                lo_q <= lo_c;
                cnt  <= is_mul ? 4'(MUL_LAT) : 4'(DIV_LAT);
            end
            if (accept && op == MTHI) HI <= A;
            if (accept && op == MTLO) LO <= A;
        end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                HI <= hi_q;
                LO <= lo_q;
            end
        end
    end
    a_no_start_busy: assert property (@(posedge clk) disable iff (!reset) !(busy && start));
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: scoreboard bench for e_mdu; expected HI/LO/latency queued at issue, checked at completion.
module tb_e_mdu;
    import mdu_pkg::*;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Req = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = MDU_NONE;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] HI, LO, MDUAns;
    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;

    e_mdu dut (
        .clk    (clk),
        .reset  (reset),
        .Req    (Req),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .MDUAns (MDUAns)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb2;
        int     ia, ib;
        sa = longint'($signed(a));
        sb2 = longint'($signed(b));
        ia = a;
        ib = b;
        if (o == MULT)  return sa * sb2;
        if (o == MULTU) return {32'd0, a} * {32'd0, b};
        if (o == DIV)   return {32'(ia % ib), 32'(ia / ib)};
        return {a % b, a / b};
    endfunction

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        sb.push_back(e);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = MDU_NONE; A = $urandom; B = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic write_hl(input logic [31:0] h, input logic [31:0] l);
        op = MTHI; A = h; start = 1'b1;
        @(posedge clk); #1;
        op = MTLO; A = l;
        @(posedge clk); #1;
        start = 1'b0; op = MDU_NONE;
    endtask

    task automatic test_reset();
        op = MFLO;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_chk++; if (HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", HI); end
        n_chk++; if (LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", LO); end
        n_chk++; if (MDUAns !== 32'd0) begin n_fail++; $display("FAIL reset_ans got %h want 0", MDUAns); end
        reset = 1'b1; op = MDU_NONE;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        logic [31:0] a, b;
        logic [3:0]  o;
        int          n;
        exp_t        e;
        for (int i = 0; i < 8; i++) begin
            o = (i % 2 == 0) ? MULT : MULTU;
            a = i < 2 ? 32'hFFFF_FFFF : $urandom;
            b = i < 2 ? 32'd2 : $urandom;
            e.lat = 5;
            {e.hi, e.lo} = i == 0 ? 64'hFFFF_FFFF_FFFF_FFFE : i == 1 ? 64'h1_FFFF_FFFE : model(o, a, b);
            issue(o, a, b, e);
            wait_done(n);
            e = sb.pop_front();
            n_chk++; if (n !== e.lat) begin n_fail++; $display("FAIL mult%0d_busy_len got %0d want %0d", i, n, e.lat); end
            n_chk++; if (HI !== e.hi) begin n_fail++; $display("FAIL mult%0d_hi got %h want %h", i, HI, e.hi); end
            n_chk++; if (LO !== e.lo) begin n_fail++; $display("FAIL mult%0d_lo got %h want %h", i, LO, e.lo); end
        end
    endtask

    task automatic test_div();
        logic [31:0] a, b;
        logic [3:0]  o;
        int          n;
        exp_t        e;
        for (int i = 0; i < 6; i++) begin
            o = (i % 2 == 0) ? DIV : DIVU;
            a = i == 0 ? 32'hFFFF_FFF9 : i == 1 ? 32'd7 : $urandom;
            b = i < 2 ? 32'd2 : $urandom_range(1, 1000);
            e.lat = 10;
            {e.hi, e.lo} = i == 0 ? 64'hFFFF_FFFF_FFFF_FFFD : i == 1 ? 64'h1_0000_0003 : model(o, a, b);
            issue(o, a, b, e);
            wait_done(n);
            e = sb.pop_front();
            n_chk++; if (n !== e.lat) begin n_fail++; $display("FAIL div%0d_busy_len got %0d want %0d", i, n, e.lat); end
            n_chk++; if (HI !== e.hi) begin n_fail++; $display("FAIL div%0d_hi got %h want %h", i, HI, e.hi); end
            n_chk++; if (LO !== e.lo) begin n_fail++; $display("FAIL div%0d_lo got %h want %h", i, LO, e.lo); end
        end
    endtask

    task automatic test_div_edge();
        int   n;
        exp_t e;
        write_hl(32'd5, 32'd6);
        e.lat = 10; e.hi = 32'd5; e.lo = 32'd6;
        issue(DIVU, 32'd99, 32'd0, e);
        wait_done(n);
        e = sb.pop_front();
        n_chk++; if (n !== e.lat) begin n_fail++; $display("FAIL divz_busy_len got %0d want %0d", n, e.lat); end
        n_chk++; if (HI !== e.hi) begin n_fail++; $display("FAIL divz_hi got %h want %h", HI, e.hi); end
        n_chk++; if (LO !== e.lo) begin n_fail++; $display("FAIL divz_lo got %h want %h", LO, e.lo); end
        e.lat = 10; e.hi = 32'd0; e.lo = 32'h8000_0000;
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, e);
        wait_done(n);
        e = sb.pop_front();
        n_chk++; if (n !== e.lat) begin n_fail++; $display("FAIL divovf_busy_len got %0d want %0d", n, e.lat); end
        n_chk++; if (HI !== e.hi) begin n_fail++; $display("FAIL divovf_hi got %h want %h", HI, e.hi); end
        n_chk++; if (LO !== e.lo) begin n_fail++; $display("FAIL divovf_lo got %h want %h", LO, e.lo); end
    endtask

    task automatic test_mt();
        op = MTHI; A = 32'h1234; start = 1'b1;
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy_start got %0b want 0", busy); end
        @(posedge clk); #1;
        start = 1'b0; op = MFHI; A = 32'hDEAD;
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy_after got %0b want 0", busy); end
        n_chk++; if (MDUAns !== 32'h1234) begin n_fail++; $display("FAIL mfhi_ans got %h want 00001234", MDUAns); end
        op = MTLO; A = 32'hABCD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = MFLO;
        #1;
        n_chk++; if (MDUAns !== 32'hABCD) begin n_fail++; $display("FAIL mflo_ans got %h want 0000abcd", MDUAns); end
        op = MDU_NONE;
        #1;
        n_chk++; if (MDUAns !== 32'd0) begin n_fail++; $display("FAIL none_ans got %h want 0", MDUAns); end
    endtask

    task automatic test_req();
        int   n;
        exp_t e;
        write_hl(32'h1111, 32'h2222);
        op = MULT; A = 32'd3; B = 32'd4; start = 1'b1; Req = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; Req = 1'b0; op = MDU_NONE;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL req_cancel_busy got %0b want 0", busy); end
        @(posedge clk); #1;
        n_chk++; if (HI !== 32'h1111) begin n_fail++; $display("FAIL req_cancel_hi got %h want 00001111", HI); end
        n_chk++; if (LO !== 32'h2222) begin n_fail++; $display("FAIL req_cancel_lo got %h want 00002222", LO); end
        e.lat = 5; e.hi = 32'd0; e.lo = 32'd12;
        issue(MULT, 32'd3, 32'd4, e);
        Req = 1'b1; op = MFHI;
        @(posedge clk); #1;
        Req = 1'b0;
        n_chk++; if (MDUAns !== 32'h1111) begin n_fail++; $display("FAIL mfhi_during_busy got %h want 00001111", MDUAns); end
        op = MDU_NONE;
        wait_done(n);
        n = n + 1;
        e = sb.pop_front();
        n_chk++; if (n !== e.lat) begin n_fail++; $display("FAIL req_busy_len got %0d want %0d", n, e.lat); end
        n_chk++; if (HI !== e.hi) begin n_fail++; $display("FAIL req_busy_hi got %h want %h", HI, e.hi); end
        n_chk++; if (LO !== e.lo) begin n_fail++; $display("FAIL req_busy_lo got %h want %h", LO, e.lo); end
    endtask

    task automatic test_async_reset();
        write_hl(32'h55, 32'h66);
        op = MULT; A = 32'd7; B = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = MFLO;
        repeat (2) begin @(posedge clk); #1; end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre_busy got %0b want 1", busy); end
        #2 reset = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %0b want 0", busy); end
        n_chk++; if (HI !== 32'd0) begin n_fail++; $display("FAIL arst_hi got %h want 0", HI); end
        n_chk++; if (LO !== 32'd0) begin n_fail++; $display("FAIL arst_lo got %h want 0", LO); end
        n_chk++; if (MDUAns !== 32'd0) begin n_fail++; $display("FAIL arst_ans got %h want 0", MDUAns); end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        n_chk++; if (LO !== 32'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_abandon got lo=%h busy=%0b want 0/0", LO, busy); end
        op = MDU_NONE;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_edge();
        test_mt();
        test_req();
        test_async_reset();
        n_chk++; if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
